led_palette_sequencer: RTL and testbench

Parametrised successor to the combinational palette mapper. It latches per-LED RGB/luminance targets and per-LED display modes, then produces registered palette values that fade toward the targets and can be modulated as static, blink or breathe. Output feeds led_pwm_driver directly; the sf_tester FSM-to-colour mapping moves upstream into target/mode generation.

---
 rtl/led_palette_pkg.sv | 27 ++
 rtl/led_palette_sequencer_if.sv | 35 +++
 rtl/led_channel_fader.sv | 50 +++++
 rtl/led_palette_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_led_palette_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/led_palette_pkg.sv
// Shared types and scaling helpers for the LED palette sequencer.
// The optional gamma stage (LED_PALETTE_GAMMA_EN) uses gamma_scale.
package led_palette_pkg;

   typedef enum logic [1:0] {
      MODE_STATIC  = 2'b00,
      MODE_BLINK   = 2'b01,
      MODE_BREATHE = 2'b10,
      MODE_OFF     = 2'b11
   } t_led_mode;

   localparam logic [7:0] c_envelope_max = 8'hFF;

   // (v*e + v) >> 8 keeps full scale at e=255 and reaches zero at e=0.
   function automatic logic [7:0] breathe_scale(input logic [7:0] v, input logic [7:0] e);
      logic [15:0] p;
      p = 16'(v) * 16'(e) + 16'(v);
      return 8'(p >> 8);
   endfunction

   function automatic logic [7:0] gamma_scale(input logic [7:0] v);
      logic [15:0] p;
      p = 16'(v) * 16'(v) + 16'd255;
      return 8'(p >> 8);
   endfunction

endpackage

// File: rtl/led_palette_sequencer_if.sv
// Target/mode load bus and palette outputs of the LED palette sequencer.
interface led_palette_sequencer_if #(
   parameter int unsigned parm_color_led_count = 4,
   parameter int unsigned parm_basic_led_count = 4
);

   logic                                i_palette_load;
   logic [8*parm_color_led_count-1:0]   i_color_red_target;
   logic [8*parm_color_led_count-1:0]   i_color_green_target;
   logic [8*parm_color_led_count-1:0]   i_color_blue_target;
   logic [2*parm_color_led_count-1:0]   i_color_mode;
   logic [8*parm_basic_led_count-1:0]   i_basic_lumin_target;
   logic [parm_basic_led_count-1:0]     i_basic_blink;
   logic [8*parm_color_led_count-1:0]   o_color_led_red_value;
   logic [8*parm_color_led_count-1:0]   o_color_led_green_value;
   logic [8*parm_color_led_count-1:0]   o_color_led_blue_value;
   logic [8*parm_basic_led_count-1:0]   o_basic_led_lumin_value;
   logic                                o_fade_busy;
   logic                                o_fade_done;

   modport master (
      output i_palette_load, i_color_red_target, i_color_green_target, i_color_blue_target,
             i_color_mode, i_basic_lumin_target, i_basic_blink,
      input  o_color_led_red_value, o_color_led_green_value, o_color_led_blue_value,
             o_basic_led_lumin_value, o_fade_busy, o_fade_done
   );

   modport slave (
      input  i_palette_load, i_color_red_target, i_color_green_target, i_color_blue_target,
             i_color_mode, i_basic_lumin_target, i_basic_blink,
      output o_color_led_red_value, o_color_led_green_value, o_color_led_blue_value,
             o_basic_led_lumin_value, o_fade_busy, o_fade_done
   );

endinterface

// File: rtl/led_channel_fader.sv
// One 8-bit channel: latched target plus a current value that ramps toward it by
// at most parm_fade_step per tick, snapping when within one step.
module led_channel_fader #(
   parameter int unsigned parm_fade_step = 8
) (
   input  logic       clk_i,
   input  logic       srst_i,
   input  logic       load_i,
   input  logic       tick_i,
   input  logic [7:0] target_i,
   output logic [7:0] current_o,
   output logic       at_target_o
);

   localparam logic [8:0] Step = 9'(parm_fade_step);

   logic [7:0] target_q, target_d;
   logic [7:0] current_q, current_d;
   logic [8:0] diff;

   // The tick compares against the target held before any coincident load.
   always_comb begin
      target_d  = load_i ? target_i : target_q;
      current_d = current_q;
      diff      = '0;
      if (tick_i) begin
         if (target_q >= current_q) begin
            diff      = {1'b0, target_q} - {1'b0, current_q};
            current_d = (diff <= Step) ? target_q : current_q + Step[7:0];
         end else begin
            diff      = {1'b0, current_q} - {1'b0, target_q};
            current_d = (diff <= Step) ? target_q : current_q - Step[7:0];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         target_q  <= '0;
         current_q <= '0;
      end else begin
         target_q  <= target_d;
         current_q <= current_d;
      end
   end

   assign current_o   = current_q;
   assign at_target_o = (current_d == target_d);

endmodule

// File: rtl/led_palette_sequencer.sv
// Fading, blinking and breathing palette generator feeding the PWM driver.
// Define LED_PALETTE_GAMMA_EN to add a registered gamma stage on every output.
module led_palette_sequencer
   import led_palette_pkg::*;
#(
   parameter int unsigned parm_color_led_count = 4,
   parameter int unsigned parm_basic_led_count = 4,
   parameter int unsigned parm_tick_divisor    = 50000,
   parameter int unsigned parm_fade_step       = 8,
   parameter int unsigned parm_blink_ticks     = 32
) (
   input logic                     i_clk,
   input logic                     i_srst,
   led_palette_sequencer_if.slave  bus
);

   localparam int unsigned NumColor  = parm_color_led_count;
   localparam int unsigned NumBasic  = parm_basic_led_count;
   localparam int unsigned NumFaders = 3 * NumColor + NumBasic;
   localparam int unsigned TickW     = (parm_tick_divisor > 1) ? $clog2(parm_tick_divisor) : 1;
   localparam int unsigned BlinkW    = (parm_blink_ticks > 1) ? $clog2(parm_blink_ticks) : 1;
   localparam logic [TickW-1:0]  TickLast  = TickW'(parm_tick_divisor - 1);
   localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(parm_blink_ticks - 1);

   logic [TickW-1:0]      tick_cnt_q, tick_cnt_d;
   logic                  tick;
   logic [7:0]            env_q, env_d;
   logic                  env_rising_q, env_rising_d;
   logic [BlinkW-1:0]     blink_cnt_q, blink_cnt_d;
   logic                  blink_phase_q, blink_phase_d;
   logic [2*NumColor-1:0] mode_q, mode_d;
   logic [NumBasic-1:0]   blink_en_q, blink_en_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [NumFaders-1:0]  at_target;

   logic [7:0] color_cur [NumColor][3];
   logic [7:0] basic_cur [NumBasic];
   logic [7:0] color_mod_q [NumColor][3];
   logic [7:0] color_mod_d [NumColor][3];
   logic [7:0] basic_mod_q [NumBasic];
   logic [7:0] basic_mod_d [NumBasic];
   logic [7:0] color_out [NumColor][3];
   logic [7:0] basic_out [NumBasic];

   for (genvar n = 0; n < NumColor; n++) begin : g_color
      logic [7:0] tgt [3];
      assign tgt[0] = bus.i_color_red_target[8*n +: 8];
      assign tgt[1] = bus.i_color_green_target[8*n +: 8];
      assign tgt[2] = bus.i_color_blue_target[8*n +: 8];
      for (genvar c = 0; c < 3; c++) begin : g_comp
         led_channel_fader #(
            .parm_fade_step (parm_fade_step)
         ) u_fader (
            .clk_i       (i_clk),
            .srst_i      (i_srst),
            .load_i      (bus.i_palette_load),
            .tick_i      (tick),
            .target_i    (tgt[c]),
            .current_o   (color_cur[n][c]),
            .at_target_o (at_target[3*n+c])
         );
      end
      assign bus.o_color_led_red_value[8*n +: 8]   = color_out[n][0];
      assign bus.o_color_led_green_value[8*n +: 8] = color_out[n][1];
      assign bus.o_color_led_blue_value[8*n +: 8]  = color_out[n][2];
   end

   for (genvar n = 0; n < NumBasic; n++) begin : g_basic
      led_channel_fader #(
         .parm_fade_step (parm_fade_step)
      ) u_fader (
         .clk_i       (i_clk),
         .srst_i      (i_srst),
         .load_i      (bus.i_palette_load),
         .tick_i      (tick),
         .target_i    (bus.i_basic_lumin_target[8*n +: 8]),
         .current_o   (basic_cur[n]),
         .at_target_o (at_target[3*NumColor+n])
      );
      assign bus.o_basic_led_lumin_value[8*n +: 8] = basic_out[n];
   end

   // Tick, envelope and blink timebase; the envelope runs regardless of mode.
   always_comb begin
      tick          = (tick_cnt_q == TickLast);
      tick_cnt_d    = tick ? '0 : tick_cnt_q + TickW'(1);
      env_d         = env_q;
      env_rising_d  = env_rising_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (tick) begin
         env_d = env_rising_q ? env_q + 8'd1 : env_q - 8'd1;
         if (env_d == c_envelope_max) begin
            env_rising_d = 1'b0;
         end else if (env_d == 8'd0) begin
            env_rising_d = 1'b1;
         end
         if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
         end
      end
      mode_d     = bus.i_palette_load ? bus.i_color_mode : mode_q;
      blink_en_d = bus.i_palette_load ? bus.i_basic_blink : blink_en_q;
      busy_d     = ~(&at_target);
      done_d     = busy_q & ~busy_d;
   end

   always_comb begin
      for (int n = 0; n < NumColor; n++) begin
         for (int c = 0; c < 3; c++) begin
            color_mod_d[n][c] = '0;
            unique case (t_led_mode'(mode_q[2*n +: 2]))
               MODE_STATIC:  color_mod_d[n][c] = color_cur[n][c];
               MODE_BLINK:   color_mod_d[n][c] = blink_phase_q ? color_cur[n][c] : 8'd0;
               MODE_BREATHE: color_mod_d[n][c] = breathe_scale(color_cur[n][c], env_q);
               MODE_OFF:     color_mod_d[n][c] = 8'd0;
            endcase
         end
      end
      for (int n = 0; n < NumBasic; n++) begin
         basic_mod_d[n] = (blink_en_q[n] && !blink_phase_q) ? 8'd0 : basic_cur[n];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         tick_cnt_q    <= '0;
         env_q         <= '0;
         env_rising_q  <= 1'b1;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         mode_q        <= '0;
         blink_en_q    <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         for (int n = 0; n < NumColor; n++) begin
            for (int c = 0; c < 3; c++) color_mod_q[n][c] <= '0;
         end
         for (int n = 0; n < NumBasic; n++) basic_mod_q[n] <= '0;
      end else begin
         tick_cnt_q    <= tick_cnt_d;
         env_q         <= env_d;
         env_rising_q  <= env_rising_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         mode_q        <= mode_d;
         blink_en_q    <= blink_en_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         for (int n = 0; n < NumColor; n++) begin
            for (int c = 0; c < 3; c++) color_mod_q[n][c] <= color_mod_d[n][c];
         end
         for (int n = 0; n < NumBasic; n++) basic_mod_q[n] <= basic_mod_d[n];
      end
   end

`ifdef LED_PALETTE_GAMMA_EN
   logic [7:0] color_gam_q [NumColor][3];
   logic [7:0] basic_gam_q [NumBasic];

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         for (int n = 0; n < NumColor; n++) begin
            for (int c = 0; c < 3; c++) color_gam_q[n][c] <= '0;
         end
         for (int n = 0; n < NumBasic; n++) basic_gam_q[n] <= '0;
      end else begin
         for (int n = 0; n < NumColor; n++) begin
            for (int c = 0; c < 3; c++) color_gam_q[n][c] <= gamma_scale(color_mod_q[n][c]);
         end
         for (int n = 0; n < NumBasic; n++) basic_gam_q[n] <= gamma_scale(basic_mod_q[n]);
      end
   end

   assign color_out = color_gam_q;
   assign basic_out = basic_gam_q;
`else
   assign color_out = color_mod_q;
   assign basic_out = basic_mod_q;
`endif

   assign bus.o_fade_busy = busy_q;
   assign bus.o_fade_done = done_q;

endmodule

// File: tb/tb_led_palette_sequencer.sv
// Scoreboard bench: stimulus schedules expected values per clock edge, a monitor
// compares them at the falling edge following that rising edge.
module tb_led_palette_sequencer;
   import led_palette_pkg::*;

   localparam int unsigned NC = 4;
   localparam int unsigned NB = 4;
`ifdef LED_PALETTE_GAMMA_EN
   localparam int unsigned Lat = 2;
`else
   localparam int unsigned Lat = 1;
`endif

   typedef struct {
      int unsigned cyc;
      int          sel;
      logic [7:0]  exp;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        srst = 1'b1;
   int unsigned cyc = 0;
   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   led_palette_sequencer_if #(.parm_color_led_count(NC), .parm_basic_led_count(NB)) bus ();

   led_palette_sequencer #(
      .parm_color_led_count (NC),
      .parm_basic_led_count (NB),
      .parm_tick_divisor    (4),
      .parm_fade_step       (8),
      .parm_blink_ticks     (2)
   ) dut (
      .i_clk  (clk),
      .i_srst (srst),
      .bus    (bus.slave)
   );

   function automatic logic [7:0] expo(input logic [7:0] v);
`ifdef LED_PALETTE_GAMMA_EN
      logic [15:0] p;
      p = 16'(v) * 16'(v) + 16'd255;
      return 8'(p >> 8);
`else
      return v;
`endif
   endfunction

   function automatic void expect_at(input int unsigned c, input int sel, input logic [7:0] v,
                                     input string name);
      exp_t e;
      int   idx;
      e.cyc = c; e.sel = sel; e.exp = v; e.name = name;
      idx = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > c) begin
            idx = i;
            break;
         end
      end
      sb.insert(idx, e);
   endfunction

   function automatic logic [7:0] sample(input int sel);
      logic any;
      any = (|bus.o_color_led_red_value) | (|bus.o_color_led_green_value) |
            (|bus.o_color_led_blue_value) | (|bus.o_basic_led_lumin_value) |
            bus.o_fade_busy | bus.o_fade_done;
      case (sel)
         0:       return bus.o_color_led_red_value[7:0];
         1:       return bus.o_color_led_green_value[15:8];
         2:       return bus.o_basic_led_lumin_value[23:16];
         3:       return {7'd0, bus.o_fade_busy};
         4:       return {7'd0, bus.o_fade_done};
         5:       return {7'd0, any};
         default: return bus.o_color_led_blue_value[31:24];
      endcase
   endfunction

   initial begin : monitor
      exp_t       e;
      logic [7:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc < cyc) begin
               failures++;
               $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
            end else begin
               act = sample(e.sel);
               if (act !== e.exp) begin
                  failures++;
                  $display("FAIL %s @%0d: got 0x%02h expected 0x%02h", e.name, cyc, act, e.exp);
               end
            end
         end
      end
   end

   task automatic goto(input int unsigned e);
      while (cyc < e) @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.i_palette_load       = 1'b0;
      bus.i_color_red_target   = '0;
      bus.i_color_green_target = '0;
      bus.i_color_blue_target  = '0;
      bus.i_color_mode         = '0;
      bus.i_basic_lumin_target = '0;
      bus.i_basic_blink        = '0;
   endtask

   // Two reset edges; returns the edge number of the last one.
   task automatic do_reset(output int unsigned r);
      r = cyc + 2;
      expect_at(r, 5, 8'd0, "reset_all_zero");
      clear_inputs();
      srst = 1'b1;
      repeat (2) @(negedge clk);
      srst = 1'b0;
   endtask

   task automatic load_at(input int unsigned e);
      goto(e - 1);
      bus.i_palette_load = 1'b1;
      @(negedge clk);
      bus.i_palette_load = 1'b0;
   endtask

   initial begin : stimulus
      int unsigned r;
      int unsigned r2;
      clear_inputs();
      @(negedge clk);

      // Single ramp 0 -> 0x20
      do_reset(r);
      bus.i_color_red_target[7:0] = 8'h20;
      expect_at(r + 1, 3, 8'd1, "a_busy_rise");
      expect_at(r + 3 + Lat, 0, expo(8'h00), "a_red_latency");
      expect_at(r + 4 + Lat, 0, expo(8'h08), "a_red_t1");
      expect_at(r + 8 + Lat, 0, expo(8'h10), "a_red_t2");
      expect_at(r + 12 + Lat, 0, expo(8'h18), "a_red_t3");
      expect_at(r + 16 + Lat, 0, expo(8'h20), "a_red_t4");
      expect_at(r + 15, 3, 8'd1, "a_busy_hold");
      expect_at(r + 15, 4, 8'd0, "a_done_early");
      expect_at(r + 16, 3, 8'd0, "a_busy_fall");
      expect_at(r + 16, 4, 8'd1, "a_done_pulse");
      expect_at(r + 17, 4, 8'd0, "a_done_end");
      load_at(r + 1);
      goto(r + 18);

      // Reversal mid-ramp, then a load equal to the current value
      do_reset(r);
      bus.i_color_red_target[7:0] = 8'hFF;
      expect_at(r + 4 + Lat, 0, expo(8'h08), "b_red_up1");
      expect_at(r + 8 + Lat, 0, expo(8'h10), "b_red_up2");
      expect_at(r + 10, 4, 8'd0, "b_no_done_reload");
      expect_at(r + 12 + Lat, 0, expo(8'h08), "b_red_down1");
      expect_at(r + 16 + Lat, 0, expo(8'h00), "b_red_down0");
      expect_at(r + 15, 3, 8'd1, "b_busy_hold");
      expect_at(r + 16, 3, 8'd0, "b_busy_fall");
      expect_at(r + 16, 4, 8'd1, "b_done_pulse");
      expect_at(r + 17, 4, 8'd0, "b_done_end");
      expect_at(r + 20, 3, 8'd0, "b_eq_busy0");
      expect_at(r + 21, 3, 8'd0, "b_eq_busy1");
      expect_at(r + 20, 4, 8'd0, "b_eq_done0");
      expect_at(r + 21, 4, 8'd0, "b_eq_done1");
      load_at(r + 1);
      bus.i_color_red_target[7:0] = 8'h00;
      load_at(r + 9);
      load_at(r + 20);
      goto(r + 22);

      // Breathe on green1; envelope value after tick k
      do_reset(r);
      bus.i_color_green_target[15:8] = 8'hFF;
      bus.i_color_mode[3:2] = MODE_BREATHE;
      expect_at(r + 4 * 10 + Lat, 1, expo(8'd3), "c_breathe_k10");
      expect_at(r + 4 * 254 + Lat, 1, expo(8'd254), "c_breathe_e254");
      expect_at(r + 4 * 255 + Lat, 1, expo(8'd255), "c_breathe_e255");
      expect_at(r + 4 * 256 + Lat, 1, expo(8'd254), "c_breathe_fall");
      expect_at(r + 4 * 510 + Lat, 1, expo(8'd0), "c_breathe_e0");
      expect_at(r + 4 * 511 + Lat, 1, expo(8'd1), "c_breathe_rise");
      load_at(r + 1);
      goto(r + 4 * 511 + Lat + 1);

      // Basic LED 2 blinking after its ramp
      do_reset(r);
      bus.i_basic_lumin_target[23:16] = 8'h80;
      bus.i_basic_blink[2] = 1'b1;
      expect_at(r + 4 * 15 + Lat, 2, expo(8'h78), "d_blink_k15");
      expect_at(r + 4 * 16 + Lat, 2, expo(8'h00), "d_blink_k16");
      expect_at(r + 4 * 17 + Lat, 2, expo(8'h00), "d_blink_k17");
      expect_at(r + 4 * 18 + Lat, 2, expo(8'h80), "d_blink_k18");
      expect_at(r + 4 * 19 + Lat, 2, expo(8'h80), "d_blink_k19");
      expect_at(r + 4 * 20 + Lat, 2, expo(8'h00), "d_blink_k20");
      expect_at(r + 4 * 21 + Lat, 2, expo(8'h00), "d_blink_k21");
      load_at(r + 1);
      goto(r + 4 * 21 + Lat + 1);

      // Reset in the middle of a ramp and blink; ticks must restart
      do_reset(r);
      bus.i_color_red_target[7:0] = 8'hFF;
      bus.i_basic_lumin_target[23:16] = 8'h80;
      bus.i_basic_blink[2] = 1'b1;
      expect_at(r + 8 + Lat, 0, expo(8'h10), "e_red_pre");
      expect_at(r + 9, 3, 8'd1, "e_busy_pre");
      load_at(r + 1);
      goto(r + 9);
      do_reset(r2);
      expect_at(r2 + 1, 3, 8'd0, "e_busy_after_rst");
      bus.i_color_red_target[7:0] = 8'h10;
      expect_at(r2 + 3 + Lat, 0, expo(8'h00), "e_red_no_tick");
      expect_at(r2 + 4 + Lat, 0, expo(8'h08), "e_red_tick1");
      expect_at(r2 + 7, 3, 8'd1, "e_busy_hold");
      expect_at(r2 + 8, 3, 8'd0, "e_busy_fall");
      expect_at(r2 + 8, 4, 8'd1, "e_done_pulse");
      load_at(r2 + 2);
      goto(r2 + 10);

      // Static blue3 with output latency check
      do_reset(r);
      bus.i_color_blue_target[31:24] = 8'h80;
      expect_at(r + 64 + Lat - 1, 6, expo(8'h78), "f_blue_pre80");
      expect_at(r + 64 + Lat, 6, expo(8'h80), "f_blue_80");
      expect_at(r + 128 + Lat - 1, 6, expo(8'hF8), "f_blue_preFF");
      expect_at(r + 128 + Lat, 6, expo(8'hFF), "f_blue_FF");
      load_at(r + 1);
      bus.i_color_blue_target[31:24] = 8'hFF;
      load_at(r + 66);
      goto(r + 128 + Lat + 1);

      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         checks   += sb.size();
         failures += sb.size();
         $display("FAIL drain: %0d checks never reached", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
